// File: rtl/vc_rr_scheduler.sv
// vc_rr_scheduler: drains four virtual-channel FIFOs (VC0..VC3) into one
// downstream FIFO. The arbiter is round-robin and grants one VC per cycle.
// The pop strobe is combinational; push/data_out follow one cycle later.
// Optional feature: define SCHED_BURST_EN to let a VC keep the grant for up
// to BURST_LEN consecutive words before the pointer moves on.
module vc_rr_scheduler #(
  parameter int DATA_W    = 10,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic [DATA_W-1:0] fifo_data3,
  input  logic              dest_pause,
  input  logic              dest_full,
  output logic [3:0]        pop,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        active_vc,
  output logic              idle,
  output logic              error
);

  typedef enum logic [1:0] {INIT, IDLE, ACTIVE, PAUSE} state_t;

  // A burst length outside 1..15 cannot be represented by the 4-bit counter.
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
    $error("vc_rr_scheduler: BURST_LEN must be within 1..15");
  end

  state_t              state, state_nxt;
  logic   [1:0]        rr_ptr, rr_nxt;
  logic   [3:0]        nonempty;
  logic                any_ready;
  logic                grant;
  logic   [1:0]        grant_idx;
  logic   [DATA_W-1:0] head_word;

  // First non-empty VC found scanning ptr, ptr+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Grant decision, one-hot pop and the head word of the granted VC.
  always_comb begin
    nonempty  = ~fifo_empty;
    any_ready = |nonempty;
    grant     = (state != INIT) && !init && !dest_pause && !dest_full && any_ready;
    grant_idx = rr_pick(nonempty, rr_ptr);
    pop       = grant ? (4'b0001 << grant_idx) : 4'b0000;
    unique case (grant_idx)
      2'd0:    head_word = fifo_data0;
      2'd1:    head_word = fifo_data1;
      2'd2:    head_word = fifo_data2;
      default: head_word = fifo_data3;
    endcase
  end

  // Next-state classification of the current cycle.
  always_comb begin
    state_nxt = state;
    if (init)                          state_nxt = INIT;
    else if (state == INIT)            state_nxt = IDLE;
    else if (!any_ready)               state_nxt = IDLE;
    else if (dest_pause || dest_full)  state_nxt = PAUSE;
    else                               state_nxt = ACTIVE;
  end

`ifdef SCHED_BURST_EN
  logic [3:0] burst_cnt, burst_nxt, burst_run;

  // Keep the pointer on the granted VC until the burst limit is reached; a
  // VC change or any idle cycle restarts the count at the next grant.
  always_comb begin
    rr_nxt    = rr_ptr;
    burst_nxt = 4'd0;
    burst_run = 4'd1;
    if (grant) begin
      if ((grant_idx == active_vc) && (burst_cnt != 4'd0)) burst_run = burst_cnt + 4'd1;
      if (burst_run == 4'(BURST_LEN)) begin
        rr_nxt    = grant_idx + 2'd1;
        burst_nxt = 4'd0;
      end else begin
        rr_nxt    = grant_idx;
        burst_nxt = burst_run;
      end
    end
  end

  // Burst counter register; grant is never true while init is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) burst_cnt <= 4'd0;
    else        burst_cnt <= burst_nxt;
  end
`else
  // Pure round-robin: move past the granted VC after every grant.
  always_comb begin
    rr_nxt = grant_idx + 2'd1;
  end
`endif

  // Control state: FSM, pointer, push strobe and sticky overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= INIT;
      rr_ptr <= 2'd0;
      push   <= 1'b0;
      error  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (init) begin
        rr_ptr <= 2'd0;
        push   <= 1'b0;
        error  <= 1'b0;
      end else begin
        push <= grant;
        if (grant) rr_ptr <= rr_nxt;
        if (push && dest_full) error <= 1'b1;
      end
    end
  end

  // Output word register: loads only on a grant, otherwise holds (also on init).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out  <= '0;
      active_vc <= 2'd0;
    end else if (grant) begin
      data_out  <= head_word;
      active_vc <= grant_idx;
    end
  end

  assign idle = (state == IDLE);

endmodule

// File: tb/tb_vc_rr_scheduler.sv
// Directed bench for vc_rr_scheduler (default build, burst mode off).
// Small queue models stand in for the four VC FIFOs; each expected push is
// queued when its pop is issued and a negedge monitor checks it.
module tb_vc_rr_scheduler;
  localparam int DATA_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              init = 1'b1;
  logic [3:0]        fifo_empty = 4'hF;
  logic [DATA_W-1:0] fifo_data0 = '0, fifo_data1 = '0, fifo_data2 = '0, fifo_data3 = '0;
  logic              dest_pause = 1'b0, dest_full = 1'b0;
  logic [3:0]        pop;
  logic              push;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        active_vc;
  logic              idle, error;

  int total = 0;
  int bad = 0;

  logic [DATA_W-1:0] q0[$], q1[$], q2[$], q3[$];
  logic [11:0]       expq[$];

  vc_rr_scheduler #(.DATA_W(DATA_W), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .init(init), .fifo_empty(fifo_empty),
    .fifo_data0(fifo_data0), .fifo_data1(fifo_data1),
    .fifo_data2(fifo_data2), .fifo_data3(fifo_data3),
    .dest_pause(dest_pause), .dest_full(dest_full),
    .pop(pop), .push(push), .data_out(data_out), .active_vc(active_vc),
    .idle(idle), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    fifo_data0 = (q0.size() != 0) ? q0[0] : '0;
    fifo_data1 = (q1.size() != 0) ? q1[0] : '0;
    fifo_data2 = (q2.size() != 0) ? q2[0] : '0;
    fifo_data3 = (q3.size() != 0) ? q3[0] : '0;
  endtask

  task automatic load(input int vc, input logic [DATA_W-1:0] w);
    case (vc)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
    refresh();
  endtask

  function automatic logic [DATA_W-1:0] head(input int vc);
    case (vc)
      0: return q0[0];
      1: return q1[0];
      2: return q2[0];
      default: return q3[0];
    endcase
  endfunction

  task automatic drop(input int vc);
    case (vc)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: void'(q3.pop_front());
    endcase
  endtask

  // One clock: check pop mid-low phase, queue the expected push, then let
  // the FIFO models retire the popped word after the rising edge.
  task automatic cyc(input logic [3:0] exp_pop, input string name);
    @(negedge clk); #1;
    check(name, {12'b0, pop}, {12'b0, exp_pop});
    for (int i = 0; i < 4; i++)
      if (exp_pop[i]) expq.push_back({2'(i), head(i)});
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      if (exp_pop[i]) drop(i);
    refresh();
  endtask

  // Monitor: every push must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [11:0] e;
    if (push) begin
      if (expq.size() == 0) begin
        check("unexpected push", {4'b0, active_vc, data_out}, 16'h0);
      end else begin
        e = expq.pop_front();
        check("push vc/data", {4'b0, active_vc, data_out}, {4'b0, e});
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    check("reset push", {15'b0, push}, 16'h0);
    check("reset data_out", {6'b0, data_out}, 16'h0);
    check("reset error", {15'b0, error}, 16'h0);
    check("reset idle", {15'b0, idle}, 16'h0);
    check("reset pop", {12'b0, pop}, 16'h0);

    // Release with init held for two cycles.
    @(posedge clk); #1 reset = 1'b1;
    cyc(4'b0000, "pop during init 1");
    cyc(4'b0000, "pop during init 2");
    check("init idle", {15'b0, idle}, 16'h0);
    check("init push", {15'b0, push}, 16'h0);
    init = 1'b0;
    cyc(4'b0000, "pop empty");
    check("idle after init", {15'b0, idle}, 16'h1);

    // Fairness across four loaded VCs.
    load(0, 10'h001); load(0, 10'h011);
    load(1, 10'h002); load(2, 10'h003); load(3, 10'h004);
    cyc(4'b0001, "fair pop vc0");
    cyc(4'b0010, "fair pop vc1");
    cyc(4'b0100, "fair pop vc2");
    cyc(4'b1000, "fair pop vc3");
    cyc(4'b0001, "fair pop vc0 again");
    cyc(4'b0000, "fair drained");
    check("idle after drain", {15'b0, idle}, 16'h1);

    // Skip/wrap: move rr_ptr to 3 via a lone VC2 grant, then VC0/VC2 only.
    load(2, 10'h0C2);
    cyc(4'b0100, "ptr setup vc2");
    load(0, 10'h0A0); load(0, 10'h0A1); load(2, 10'h0C3);
    cyc(4'b0001, "wrap vc0");
    cyc(4'b0100, "skip to vc2");
    cyc(4'b0001, "wrap vc0 again");
    cyc(4'b0000, "skip drained");

    // Flow control: pause mid-stream, then resume at the saved pointer.
    load(0, 10'h100); load(0, 10'h101); load(0, 10'h102);
    load(1, 10'h110); load(1, 10'h111);
    cyc(4'b0010, "stream vc1");
    cyc(4'b0001, "stream vc0");
    dest_pause = 1'b1;
    cyc(4'b0000, "pause blocks pop");
    check("no push after pause", {15'b0, push}, 16'h0);
    check("pause not idle", {15'b0, idle}, 16'h0);
    cyc(4'b0000, "pause holds");
    dest_pause = 1'b0;
    cyc(4'b0010, "resume vc1");
    cyc(4'b0001, "resume vc0");
    cyc(4'b0001, "resume vc0 last");
    cyc(4'b0000, "flow drained");

    // Overflow: downstream full while a push is presented.
    load(3, 10'h3F0);
    cyc(4'b1000, "overflow src vc3");
    dest_full = 1'b1;
    cyc(4'b0000, "full blocks pop");
    check("error set", {15'b0, error}, 16'h1);
    cyc(4'b0000, "full holds");
    check("error sticky full", {15'b0, error}, 16'h1);
    dest_full = 1'b0;
    cyc(4'b0000, "after full");
    check("error sticky", {15'b0, error}, 16'h1);
    init = 1'b1;
    cyc(4'b0000, "init pulse");
    check("error cleared by init", {15'b0, error}, 16'h0);
    check("data_out held on init", {6'b0, data_out}, 16'h3F0);
    init = 1'b0;
    cyc(4'b0000, "post init");
    check("idle post init", {15'b0, idle}, 16'h1);

    // Reset mid-transfer drops outputs immediately; the pending word is lost.
    load(1, 10'h055);
    cyc(4'b0010, "pre-reset vc1");
    reset = 1'b0;
    #1;
    check("async push", {15'b0, push}, 16'h0);
    check("async data_out", {6'b0, data_out}, 16'h0);
    check("async active_vc", {14'b0, active_vc}, 16'h0);
    expq.delete();
    @(posedge clk); #1 reset = 1'b1;
    cyc(4'b0000, "after reset");
    check("idle after reset", {15'b0, idle}, 16'h1);

    check("scoreboard drained", 16'(expq.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_rr_scheduler.md
# vc_rr_scheduler

Round-robin scheduler that drains the four virtual-channel TLP FIFOs (VC0–VC3) into one shared downstream FIFO. It sits between the per-VC FIFOs and the single egress FIFO, and is sequenced by the same `init`/`pause` flow-control signals the FIFO supervisor FSM uses. Each cycle it grants at most one non-empty VC and issues a one-hot `pop`. It registers the popped word and a `push` toward the downstream FIFO, and reports idle and overflow-error status.

## Interface
- `DATA_W`, 10: TLP word width per FIFO entry.
- `BURST_LEN`, 4: maximum consecutive grants to one VC. Used only when `SCHED_BURST_EN` is defined. Legal range 1–15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `init`  in  1  synchronous re-initialisation request, active-high.
- `fifo_empty`  in  4  empty flag of each VC FIFO (bit i = VCi).
- `fifo_data0`..`fifo_data3`  in  DATA_W each  head word of each VC FIFO (show-ahead: valid whenever not empty).
- `dest_pause`  in  1  downstream almost-full; no new grants while high.
- `dest_full`  in  1  downstream full; no new grants while high.
- `pop`  out  4  one-hot read strobe to the VC FIFOs (combinational).
- `push`  out  1  registered write strobe to the downstream FIFO.
- `data_out`  out  DATA_W  registered word for the downstream FIFO.
- `active_vc`  out  2  VC index that sourced the current `data_out`.
- `idle`  out  1  high in state IDLE.
- `error`  out  1  sticky overflow flag.

## Operation
- States: INIT, IDLE, ACTIVE, PAUSE. The state register holds the classification of the previous cycle.
- The reset value of every register is 0: `push`, `data_out`, `active_vc`, `error`, the round-robin pointer `rr_ptr`, and the burst counter. The state after reset is INIT.
- Transitions (evaluated each edge):
  - `init`=1 → INIT from any state.
  - INIT → IDLE when `init`=0.
  - Otherwise:
    - all VCs empty → IDLE;
    - any VC non-empty and (`dest_pause` | `dest_full`) → PAUSE;
    - any VC non-empty and not paused → ACTIVE.
- Grant condition in the current cycle:
  - state ≠ INIT, `init`=0, `dest_pause`=0, `dest_full`=0, and `fifo_empty` ≠ 4'b1111.
  - The granted VC is the first non-empty VC scanning `rr_ptr`, `rr_ptr+1`, … mod 4.
  - `pop` = one-hot of the granted VC, otherwise 4'b0000.
- On a grant edge:
  - `data_out` ← head word of the granted VC; `active_vc` ← granted index; `push` ← 1.
  - `rr_ptr` ← granted+1 mod 4 (wrap 3→0).
- On a non-grant edge: `push` ← 0. `data_out` and `active_vc` hold their values.
- `error` is set on any edge where `push`=1 and `dest_full`=1. It is cleared only by `reset` or by `init`.
- `init`=1 clears `rr_ptr`, the burst counter, `push` and `error`. `data_out` holds its value.
- Reset asserted mid-transfer: all outputs drop to 0 asynchronously. A word already popped but not yet pushed is lost; this is acceptable.

## Timing
- `pop` is combinational in the grant cycle N. The matching `push`/`data_out` are valid in cycle N+1 (1-cycle latency).
- Sustained throughput is 1 word/cycle with no bubbles on VC switches.
- `dest_pause` rising in cycle N blocks the grant in cycle N itself. At most one word (from cycle N−1) still arrives, so the downstream almost-full threshold must be ≤ depth−1.
- A VC that empties in the same cycle it is granted is skipped from the next cycle on, because the FIFO updates `fifo_empty`.
- `idle` lags the FIFO flags by one cycle, since it is decoded from the registered state.

## Configuration
- `SCHED_BURST_EN` defined:
  - A granted VC keeps the grant (`rr_ptr` is not advanced) for up to `BURST_LEN` consecutive grants, or until it goes empty, whichever comes first.
  - `rr_ptr` then advances to granted+1.
  - The burst counter resets on a VC change, on any non-grant cycle, and on `init`.
- `SCHED_BURST_EN` undefined:
  - Pure round-robin: `rr_ptr` advances after every grant.
  - The burst counter is not instantiated.

## Test plan
- Reset/init: `reset`=0, then release with `init`=1 for 2 cycles → `pop`=0, `push`=0, `error`=0, `idle`=0. After `init`=0 with all FIFOs empty → `idle`=1 one cycle later.
- Fairness: all four VCs non-empty, heads 0x001/0x002/0x003/0x004, burst disabled → `pop` sequence 0001, 0010, 0100, 1000, 0001 → `active_vc` 0,1,2,3,0, each one cycle after its pop.
- Skip/wrap: `fifo_empty`=4'b1010, `rr_ptr`=3 → grants VC0, then VC2, then VC0. VC3 and VC1 are never popped.
- Flow control: raise `dest_pause` mid-stream → `pop`=0 in that same cycle, at most one further `push`, state PAUSE. Drop `dest_pause` → grants resume at the saved `rr_ptr`.
- Overflow: force `dest_full`=1 while `push`=1 → `error`=1 next cycle and stays 1 until `init` pulse.
- Burst (`SCHED_BURST_EN`, `BURST_LEN`=3): VC0 holds 5 words, VC1 holds 2 words → pops VC0,VC0,VC0,VC1,VC1,VC0,VC0.
